// File: rtl/fifo_merge_pkg.sv
// fifo_merge_pkg: shared helpers for the FIFO round-robin merger family.
//   clog2_min1 : ceil(log2(v)), never below 1, so 1-entry vectors still get a bit.
//   out_width  : width of the merged output word. It includes the source tag
//                when FIFO_RR_MERGE_TAG_EN is defined.
//   grant_idx_t: grant index wide enough for the largest supported fan-in (16).
package fifo_merge_pkg;

  localparam int MAX_INPUTS = 16;

  typedef logic [3:0] grant_idx_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int out_width(input int data_w, input int idx_w);
`ifdef FIFO_RR_MERGE_TAG_EN
    return data_w + idx_w;
`else
    return data_w + 0 * idx_w;
`endif
  endfunction

endpackage

// File: rtl/fifo_rr_merge_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req_i   : request vector
//   start_i : index that has the highest priority; priority then wraps upward
//   gnt_o   : one-hot grant, or zero when there is no request
//   vld_o   : at least one request was granted
module rr_pick
  import fifo_merge_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_merge.sv
// fifo_rr_merge: merges NUM_IN FWFT FIFO read ports into one downstream FIFO
// write port. Arbitration is round-robin with bounded burst locking, so a
// granted input keeps the grant for up to BURST_LEN consecutive words. The
// output register sustains one word per cycle, with 1-cycle latency.
//   clk, reset  : clock; asynchronous active-high reset
//   in_empty_n  : per-input not-empty
//   in_read     : per-input read strobe (one-hot or zero)
//   in_dout     : packed input data, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n  : downstream not-full
//   out_write   : downstream write strobe
//   out_din     : output word, {source index, data} when FIFO_RR_MERGE_TAG_EN is defined
//   cur_grant   : index of the last granted input
// Optional feature macro: FIFO_RR_MERGE_TAG_EN.
module fifo_rr_merge
  import fifo_merge_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int IDX_WIDTH  = clog2_min1(NUM_IN),
  localparam int OUT_WIDTH = out_width(DATA_WIDTH, IDX_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_empty_n,
  output logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [OUT_WIDTH-1:0]         out_din,
  output logic [IDX_WIDTH-1:0]         cur_grant
);

  localparam int CNT_W = clog2_min1(BURST_LEN);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [IDX_WIDTH-1:0]  cur_grant_q, cur_grant_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  // Set when the previous accepting cycle moved a word from cur_grant. A stall
  // leaves it untouched, so a burst resumes where it stopped.
  logic                  last_xfer_q, last_xfer_d;

  logic                  accept, hold, sel_vld;
  logic [IDX_WIDTH-1:0]  start_idx, pick_idx, sel_idx;
  logic [NUM_IN-1:0]     pick_gnt;
  logic                  pick_vld;

  assign accept = !out_valid_q || out_full_n;

  // With BURST_LEN=1 the compare is never true, and the hold path folds away.
  assign hold = last_xfer_q && in_empty_n[cur_grant_q] &&
                (int'(burst_cnt_q) < BURST_LEN - 1);

  // Rotation starts just after the current grant, so cur_grant is searched last.
  assign start_idx = (cur_grant_q == IDX_WIDTH'(NUM_IN - 1)) ? '0
                                                             : cur_grant_q + IDX_WIDTH'(1);

  rr_pick #(.N(NUM_IN), .IW(IDX_WIDTH)) u_pick (
    .req_i   (in_empty_n),
    .start_i (start_idx),
    .gnt_o   (pick_gnt),
    .vld_o   (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (pick_gnt[i]) pick_idx = IDX_WIDTH'(i);
  end

  assign sel_idx = hold ? cur_grant_q : pick_idx;
  // Reset gates the read strobe, so no word is popped while the block is held.
  assign sel_vld = accept && !reset && (hold || pick_vld);
  assign in_read = sel_vld ? (NUM_IN'(1) << sel_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cur_grant_d = cur_grant_q;
    burst_cnt_d = burst_cnt_q;
    last_xfer_d = last_xfer_q;
    if (accept) begin
      if (sel_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = in_dout[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        cur_grant_d = sel_idx;
        burst_cnt_d = hold ? burst_cnt_q + CNT_W'(1) : '0;
        last_xfer_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        last_xfer_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cur_grant_q <= '0;
      burst_cnt_q <= '0;
      last_xfer_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cur_grant_q <= cur_grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_xfer_q <= last_xfer_d;
    end
  end

`ifdef FIFO_RR_MERGE_TAG_EN
  logic [IDX_WIDTH-1:0] tag_q, tag_d;

  assign tag_d = (accept && sel_vld) ? sel_idx : tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  assign out_din = {tag_q, out_data_q};
`else
  assign out_din = out_data_q;
`endif

  assign out_write = out_valid_q;
  assign cur_grant = cur_grant_q;

endmodule
